// File: rtl/ofifo_drain_pkg.sv
// Shared types and constants for the OFIFO drain controller.
// DRAIN_SAT_EN selects saturating accumulate in psum_lane_alu.
package ofifo_drain_pkg;

  localparam int COL     = 8;
  localparam int PSUM_BW = 16;
  localparam int ADDR_W  = 4;
  localparam int ROW_W   = COL * PSUM_BW;

  localparam logic [PSUM_BW-1:0] PSUM_MAX =
    {1'b0, {(PSUM_BW-1){1'b1}}};
  localparam logic [PSUM_BW-1:0] PSUM_MIN =
    {1'b1, {(PSUM_BW-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RDWAIT,
    S_WRITE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] nrows;
    logic              first;
    logic              last;
  } cfg_t;

endpackage

// File: rtl/ofifo_drain_if.sv
// Control, OFIFO and psum SRAM bundle for ofifo_drain.
// master: sequencer/OFIFO/SRAM side, slave: drain controller.
interface ofifo_drain_if;
  import ofifo_drain_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_rows;
  logic              first_pass;
  logic              last_pass;
  logic              busy;
  logic              done;

  logic              ofifo_valid;
  logic [ROW_W-1:0]  ofifo_output;
  logic              ofifo_rd;

  logic              mem_cen;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_a;
  logic [ROW_W-1:0]  mem_d;
  logic [ROW_W-1:0]  mem_q;

  modport master (
    output start, base_addr, num_rows,
    output first_pass, last_pass,
    output ofifo_valid, ofifo_output, mem_q,
    input  busy, done, ofifo_rd,
    input  mem_cen, mem_wen, mem_a, mem_d
  );

  modport slave (
    input  start, base_addr, num_rows,
    input  first_pass, last_pass,
    input  ofifo_valid, ofifo_output, mem_q,
    output busy, done, ofifo_rd,
    output mem_cen, mem_wen, mem_a, mem_d
  );

endinterface

// File: rtl/ofifo_drain_psum_lane_alu.sv
// One psum lane: add (bypassed on first pass), clamp, ReLU.
// DRAIN_SAT_EN saturates the accumulate instead of wrapping.
module psum_lane_alu
  import ofifo_drain_pkg::*;
(
  input  logic [PSUM_BW-1:0] row_i,
  input  logic [PSUM_BW-1:0] mem_i,
  input  logic               first_i,
  input  logic               relu_i,
  output logic [PSUM_BW-1:0] res_o
);

  logic [PSUM_BW-1:0] acc_w;
  logic [PSUM_BW-1:0] pre_w;

`ifdef DRAIN_SAT_EN
  logic [PSUM_BW:0] sum_w;
  logic             ovf_w;

  assign sum_w = {row_i[PSUM_BW-1], row_i}
               + {mem_i[PSUM_BW-1], mem_i};
  // Guard and sign bits disagree only on overflow.
  assign ovf_w = sum_w[PSUM_BW] ^ sum_w[PSUM_BW-1];
  assign acc_w = !ovf_w ? sum_w[PSUM_BW-1:0]
               : (sum_w[PSUM_BW] ? PSUM_MIN : PSUM_MAX);
`else
  assign acc_w = row_i + mem_i;
`endif

  assign pre_w = first_i ? row_i : acc_w;
  assign res_o = (relu_i && pre_w[PSUM_BW-1])
               ? '0 : pre_w;

endmodule

// File: rtl/ofifo_drain.sv
// OFIFO-to-psum-SRAM drain: store, accumulate, ReLU per pass.
// Build with DRAIN_SAT_EN for saturating accumulate.
module ofifo_drain
  import ofifo_drain_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  ofifo_drain_if.slave  bus
);

  state_e            state_q, state_d;
  cfg_t              cfg_q, cfg_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  memd_q, memd_d;

  logic [ROW_W-1:0]  alu_row_w;
  logic [ROW_W-1:0]  alu_y_w;
  logic              rd_w;
  logic              wr_w;

  // First pass feeds the OFIFO head straight in; else the held row.
  assign alu_row_w = (state_q == S_WAIT)
                   ? bus.ofifo_output : row_q;

  for (genvar i = 0; i < COL; i++) begin : g_lane
    psum_lane_alu u_alu (
      .row_i   (alu_row_w[i*PSUM_BW +: PSUM_BW]),
      .mem_i   (bus.mem_q[i*PSUM_BW +: PSUM_BW]),
      .first_i (cfg_q.first),
      .relu_i  (cfg_q.last),
      .res_o   (alu_y_w[i*PSUM_BW +: PSUM_BW])
    );
  end

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    memd_d  = memd_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cfg_d.nrows = bus.num_rows;
          cfg_d.first = bus.first_pass;
          cfg_d.last  = bus.last_pass;
          addr_d      = bus.base_addr;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.ofifo_valid) begin
          row_d = bus.ofifo_output;
          if (cfg_q.first) begin
            memd_d  = alu_y_w;
            state_d = S_WRITE;
          end else begin
            state_d = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        memd_d  = alu_y_w;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        addr_d = addr_q + 1'b1;
        if (cnt_q == cfg_q.nrows) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_WAIT;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      memd_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      memd_q  <= memd_d;
    end
  end

  // Strobes are gated by reset so an edge under reset never writes.
  assign rd_w = (state_q == S_WAIT) & bus.ofifo_valid;
  assign wr_w = (state_q == S_WRITE);

  assign bus.ofifo_rd = reset & rd_w;
  assign bus.mem_cen  =
    ~(reset & ((rd_w & ~cfg_q.first) | wr_w));
  assign bus.mem_wen  = ~(reset & wr_w);
  assign bus.mem_a    = addr_q;
  assign bus.mem_d    = memd_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);

endmodule

// File: tb/tb_ofifo_drain.sv
// Randomized bench for ofifo_drain against a row-level model.
// Build with DRAIN_SAT_EN to check the saturating variant.
module tb_ofifo_drain;
  import ofifo_drain_pkg::*;

  typedef logic [ROW_W-1:0] row_t;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int LIM   = 1 << (PSUM_BW - 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;

  ofifo_drain_if bus();

  ofifo_drain u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [ROW_W-1:0] obs,
                     input logic [ROW_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  row_t sram[DEPTH];
  row_t ref_mem[DEPTH];
  row_t fifo_q[$];
  int   wr_a[$];
  row_t wr_d[$];
  int   rdl_a[$];
  int   rd_cnt    = 0;
  int   stall_pct = 0;
  int   hold_cnt  = 0;
  bit   exp_rd    = 1'b0;

  // Behavioural SRAM: q holds until the next read.
  always @(posedge clk) begin
    if (bus.mem_cen === 1'b0) begin
      if (bus.mem_wen === 1'b0) sram[bus.mem_a] <= bus.mem_d;
      else bus.mem_q <= sram[bus.mem_a];
    end
  end

  // OFIFO head driver, stable for the whole cycle.
  always @(posedge clk) begin
    #1;
    if (hold_cnt > 0 || fifo_q.size() == 0 ||
        $urandom_range(99) < stall_pct) begin
      bus.ofifo_valid = 1'b0;
    end else begin
      bus.ofifo_valid = 1'b1;
    end
    bus.ofifo_output = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Mid-cycle monitor: pops, logs SRAM traffic, stall checks.
  always @(negedge clk) begin
    if (bus.ofifo_rd) begin
      chk("rd_valid", bus.ofifo_valid, 1);
      rd_cnt++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (!bus.mem_cen && !bus.mem_wen) begin
      wr_a.push_back(int'(bus.mem_a));
      wr_d.push_back(bus.mem_d);
    end
    if (!bus.mem_cen && bus.mem_wen) rdl_a.push_back(int'(bus.mem_a));
    if (exp_rd) begin
      chk("resume_rd", bus.ofifo_rd, 1);
      exp_rd = 1'b0;
    end
    if (hold_cnt > 0) begin
      chk("stall_rd", bus.ofifo_rd, 0);
      chk("stall_cen", bus.mem_cen, 1);
      chk("stall_busy", bus.busy, 1);
      hold_cnt--;
      if (hold_cnt == 0) exp_rd = 1'b1;
    end
  end

  function automatic row_t fill(input int v);
    row_t r;
    for (int l = 0; l < COL; l++) r[l*PSUM_BW +: PSUM_BW] = PSUM_BW'(v);
    return r;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    int   v;
    for (int l = 0; l < COL; l++) begin
      case ($urandom_range(3))
        0: v = LIM - 1;
        1: v = -LIM;
        2: v = int'($urandom_range(200)) - 100;
        default: v = int'($urandom);
      endcase
      r[l*PSUM_BW +: PSUM_BW] = PSUM_BW'(v);
    end
    return r;
  endfunction

  // Lane arithmetic on plain integers.
  function automatic row_t ref_row(input row_t old, input row_t r,
                                   input bit fp, input bit lp);
    row_t res;
    logic signed [PSUM_BW-1:0] x;
    logic signed [PSUM_BW-1:0] y;
    int s;
    for (int l = 0; l < COL; l++) begin
      x = r[l*PSUM_BW +: PSUM_BW];
      y = old[l*PSUM_BW +: PSUM_BW];
      s = int'(x);
      if (!fp) begin
        s = s + int'(y);
`ifdef DRAIN_SAT_EN
        if (s > LIM - 1) s = LIM - 1;
        if (s < -LIM) s = -LIM;
`else
        s = ((s % (2 * LIM)) + 2 * LIM) % (2 * LIM);
        if (s >= LIM) s = s - 2 * LIM;
`endif
      end
      if (lp && s < 0) s = 0;
      res[l*PSUM_BW +: PSUM_BW] = PSUM_BW'(s);
    end
    return res;
  endfunction

  task automatic run_pass(input int base, input int n,
                          input bit fp, input bit lp,
                          input row_t rows[$],
                          input int stall, input int hold);
    int   exp_a[$];
    row_t exp_d[$];
    int   a;
    int   lat;
    rd_cnt = 0;
    wr_a.delete();
    wr_d.delete();
    rdl_a.delete();
    for (int i = 0; i <= n; i++) begin
      a = (base + i) % DEPTH;
      ref_mem[a] = ref_row(ref_mem[a], rows[i], fp, lp);
      exp_a.push_back(a);
      exp_d.push_back(ref_mem[a]);
    end
    stall_pct = stall;
    hold_cnt  = hold;
    for (int i = 0; i <= n; i++) fifo_q.push_back(rows[i]);
    bus.start      = 1'b1;
    bus.base_addr  = ADDR_W'(base);
    bus.num_rows   = ADDR_W'(n);
    bus.first_pass = fp;
    bus.last_pass  = lp;
    lat = 1;
    do begin
      @(negedge clk); #1;
      lat++;
      if (lat == 2) begin
        bus.start      = 1'b0;
        bus.base_addr  = ADDR_W'($urandom);
        bus.num_rows   = ADDR_W'($urandom);
        bus.first_pass = 1'($urandom);
        bus.last_pass  = 1'($urandom);
      end
    end while (!bus.done && lat < 3000);
    chk("done_seen", bus.done, 1);
    chk("busy_at_done", bus.busy, 1);
    if (stall == 0)
      chk("latency", lat, 2 + (fp ? 2 : 3) * (n + 1) + hold);
    @(negedge clk); #1;
    stall_pct = 0;
    chk("done_pulse", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("rd_cnt", rd_cnt, n + 1);
    chk("wr_cnt", wr_a.size(), n + 1);
    chk("rdl_cnt", rdl_a.size(), fp ? 0 : n + 1);
    for (int i = 0; i <= n; i++) begin
      if (i < wr_a.size()) begin
        chk("wr_addr", wr_a[i], exp_a[i]);
        chk("wr_data", wr_d[i], exp_d[i]);
      end
      if (!fp && i < rdl_a.size()) chk("rd_addr", rdl_a[i], exp_a[i]);
    end
    for (int k = 0; k < DEPTH; k++) chk("sram", sram[k], ref_mem[k]);
  endtask

  task automatic reset_mid();
    row_t rows[$];
    int   t;
    for (int i = 0; i < 3; i++) rows.push_back(rand_row());
    rd_cnt = 0;
    wr_a.delete();
    rdl_a.delete();
    for (int i = 0; i < 3; i++) fifo_q.push_back(rows[i]);
    bus.start      = 1'b1;
    bus.base_addr  = ADDR_W'(4);
    bus.num_rows   = ADDR_W'(2);
    bus.first_pass = 1'b0;
    bus.last_pass  = 1'b0;
    @(negedge clk); #1;
    bus.start = 1'b0;
    t = 0;
    while (rdl_a.size() == 0 && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    chk("rst_read_seen", rdl_a.size(), 1);
    @(negedge clk); #1;
    chk("rdwait_cen", bus.mem_cen, 1);
    reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_cen", bus.mem_cen, 1);
    chk("rst_wen", bus.mem_wen, 1);
    chk("rst_rd", bus.ofifo_rd, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_mem_a", bus.mem_a, 0);
    chk("rst_no_write", wr_a.size(), 0);
    reset = 1'b1;
    fifo_q.delete();
    @(negedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    row_t rows[$];
    row_t r;
    int   base, n, stall, hold;
    bit   fp, lp;
    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.num_rows   = '0;
    bus.first_pass = 1'b0;
    bus.last_pass  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      sram[k]    = '0;
      ref_mem[k] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_v_rd", bus.ofifo_rd, 0);
    chk("rst_v_cen", bus.mem_cen, 1);
    chk("rst_v_wen", bus.mem_wen, 1);
    chk("rst_v_a", bus.mem_a, 0);
    chk("rst_v_d", bus.mem_d, 0);
    chk("rst_v_busy", bus.busy, 0);
    chk("rst_v_done", bus.done, 0);
    reset = 1'b1;
    @(negedge clk); #1;

    rows = {fill(5), fill(-3)};
    run_pass(2, 1, 1'b1, 1'b0, rows, 0, 0);
    chk("store_row2", sram[2], fill(5));
    chk("store_row3", sram[3], fill(-3));

    rows = {fill(-8)};
    run_pass(2, 0, 1'b0, 1'b1, rows, 0, 0);
    chk("relu_row2", sram[2], fill(0));

    rows = {rand_row(), rand_row()};
    run_pass(5, 1, 1'b0, 1'b0, rows, 0, 10);

    rows = {rand_row(), rand_row()};
    run_pass(15, 1, 1'b1, 1'b0, rows, 0, 0);
    chk("wrap_first", (wr_a.size() > 0) ? wr_a[0] : -1, 15);
    chk("wrap_second", (wr_a.size() > 1) ? wr_a[1] : -1, 0);

    r = fill(100);
    r[PSUM_BW-1:0] = PSUM_MAX;
    rows = {r};
    run_pass(8, 0, 1'b1, 1'b0, rows, 0, 0);
    rows = {fill(1)};
    run_pass(8, 0, 1'b0, 1'b0, rows, 0, 0);
`ifdef DRAIN_SAT_EN
    chk("sat_lane0", sram[8][PSUM_BW-1:0], PSUM_MAX);
`else
    chk("sat_lane0", sram[8][PSUM_BW-1:0], PSUM_MIN);
`endif

    reset_mid();
    rows = {rand_row(), rand_row(), rand_row()};
    run_pass(4, 2, 1'b0, 1'b0, rows, 0, 0);

    for (int p = 0; p < 12; p++) begin
      base  = int'($urandom_range(DEPTH - 1));
      n     = int'($urandom_range(5));
      fp    = 1'($urandom);
      lp    = 1'($urandom);
      stall = ($urandom_range(1) == 0) ? 0 : 30;
      hold  = ($urandom_range(3) == 0) ? int'($urandom_range(1, 4)) : 0;
      rows.delete();
      for (int i = 0; i <= n; i++) rows.push_back(rand_row());
      run_pass(base, n, fp, lp, rows, stall, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
